// File: rtl/mcla_pipe_adder.sv
// Pipelined adder/subtractor built from 4-bit MCLA blocks with two-level lookahead.
// The block chain is cut into STAGES register stages, and the carry between stages is registered.
module mcla_pipe_adder #(
    parameter int WIDTH  = 20,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NB  = WIDTH / 4;
    localparam int BPS = (NB + STAGES - 1) / STAGES;

    // Handshake: a beat transfers on a rising edge when valid && ready on that side.
    // The pipe moves as a unit whenever the output register is empty or being drained,
    // so in_ready mirrors that advance enable.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] c_q, cm_q, v_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_n  [STAGES];
    logic [WIDTH-1:0]  bx_n [STAGES];
    logic [WIDTH-1:0]  s_n  [STAGES];
    logic [STAGES-1:0] c_n, cm_n, v_in;

    function automatic logic [1:0] blk_gp(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] g;
        logic [3:0] p;
        g = x & y;
        p = x ^ y;
        blk_gp[1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        blk_gp[0] = &p;
    endfunction

    // Returns {carry into bit 3, 4-bit sum}.
    function automatic logic [4:0] blk_sum(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g = x & y;
        p = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        blk_sum = {c[3], p ^ c};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * BPS < NB) ? k * BPS : NB;
        localparam int HI = ((k + 1) * BPS < NB) ? (k + 1) * BPS : NB;

        logic [WIDTH-1:0] a_i, bx_i, s_i, s_o;
        logic             c_i, cm_i, cm_o;
        logic [NB-1:0]    g, p;
        logic [NB:0]      bc;
        logic             acc, term;
        logic [4:0]       blk;

        if (k == 0) begin : g_head
            assign a_i  = a;
            assign bx_i = sub ? ~b : b;
            assign s_i  = '0;
            assign c_i  = sub | cin;
            assign cm_i = 1'b0;
        end else begin : g_body
            assign a_i  = a_q[k-1];
            assign bx_i = bx_q[k-1];
            assign s_i  = s_q[k-1];
            assign c_i  = c_q[k-1];
            assign cm_i = cm_q[k-1];
        end

        // Each block carry is a flat sum of products of block g/p and the stage carry-in.
        always_comb begin
            g    = '0;
            p    = '0;
            bc   = '0;
            acc  = 1'b0;
            term = 1'b0;
            blk  = '0;
            s_o  = s_i;
            cm_o = cm_i;
            for (int j = LO; j < HI; j++) begin
                {g[j], p[j]} = blk_gp(a_i[4*j +: 4], bx_i[4*j +: 4]);
            end
            bc[LO] = c_i;
            for (int j = LO + 1; j <= HI; j++) begin
                acc = c_i;
                for (int i = LO; i < j; i++) acc = acc & p[i];
                for (int i = LO; i < j; i++) begin
                    term = g[i];
                    for (int m = i + 1; m < j; m++) term = term & p[m];
                    acc = acc | term;
                end
                bc[j] = acc;
            end
            for (int j = LO; j < HI; j++) begin
                blk = blk_sum(a_i[4*j +: 4], bx_i[4*j +: 4], bc[j]);
                s_o[4*j +: 4] = blk[3:0];
                if (j == NB - 1) cm_o = blk[4];
            end
        end

        assign a_n[k]  = a_i;
        assign bx_n[k] = bx_i;
        assign s_n[k]  = s_o;
        assign c_n[k]  = bc[HI];
        assign cm_n[k] = cm_o;
    end

    always_comb begin
        v_in    = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) v_in[k] = v_q[k-1];
    end

    // Data registers load only with a valid beat, so bubbles hold the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            cm_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (en) begin
            v_q <= v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k]  <= a_n[k];
                    bx_q[k] <= bx_n[k];
                    s_q[k]  <= s_n[k];
                    c_q[k]  <= c_n[k];
                    cm_q[k] <= cm_n[k];
                end
            end
            if (v_in[STAGES-1]) ovf_q <= cm_n[STAGES-1] ^ c_n[STAGES-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mcla_pipe_adder.sv
// Bench for mcla_pipe_adder: directed vectors and corner sequences on a 20-bit/2-stage
// instance, plus random traffic on several width/stage configurations against an arithmetic model.
module tb_mcla_pipe_adder;
    localparam int MW = 20;
    localparam int MS = 2;
    localparam int NX = 6;
    localparam int CW [NX] = '{4, 20, 20, 20, 32, 32};
    localparam int CS [NX] = '{1, 1, 3, 5, 1, 8};
    localparam int NRAND = 3000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [MW-1:0] a, b, s;

    mcla_pipe_adder #(.WIDTH(MW), .STAGES(MS)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    logic          xvalid, xcin, xsub;
    logic [31:0]   xa, xb;
    logic [31:0]   x_s [NX];
    logic [NX-1:0] x_ov, x_cout, x_ovf, x_ir;

    for (genvar i = 0; i < NX; i++) begin : g_x
        localparam int W = CW[i];
        logic [W-1:0] s_l;
        logic ir_l, ov_l, co_l, of_l;
        mcla_pipe_adder #(.WIDTH(W), .STAGES(CS[i])) u_x (
            .clk(clk), .rst_n(rst_n), .in_valid(xvalid), .in_ready(ir_l),
            .a(xa[W-1:0]), .b(xb[W-1:0]), .cin(xcin), .sub(xsub), .out_valid(ov_l),
            .out_ready(1'b1), .s(s_l), .cout(co_l), .ovf(of_l)
        );
        assign x_s[i]    = 32'(s_l);
        assign x_ir[i]   = ir_l;
        assign x_ov[i]   = ov_l;
        assign x_cout[i] = co_l;
        assign x_ovf[i]  = of_l;
    end

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic          cin;
        logic          sub;
        logic [MW-1:0] s;
        logic          cout;
        logic          ovf;
    } vec_t;

    vec_t        vecs [8];
    logic [33:0] exp_q [$];
    logic [33:0] xq [NX][$];
    int          xt [NX][$];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic sb);
        logic [63:0] mask, xx, yy, sum;
        logic [31:0] r;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        xx   = {32'd0, x} & mask;
        yy   = sb ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
        sum  = xx + yy + {63'd0, (sb ? 1'b1 : ci)};
        r    = sum[31:0] & mask[31:0];
        co   = sum[w];
        ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        return {ov, co, r};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, sent, got;
        logic        hold, stall_prev;
        logic [33:0] held, act;

        vecs[0] = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1};
        vecs[1] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[2] = '{20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00001, 1'b0, 1'b0};
        vecs[3] = '{20'h00005, 20'h00007, 1'b1, 1'b1, 20'hFFFFE, 1'b0, 1'b0};
        vecs[4] = '{20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1};
        vecs[5] = '{20'hAAAAA, 20'h55555, 1'b1, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[6] = '{20'h3C3C3, 20'h3C3C3, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0};
        vecs[7] = '{20'h00000, 20'h80000, 1'b0, 1'b1, 20'h80000, 1'b0, 1'b1};

        in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
        xvalid = 0; xa = '0; xb = '0; xcin = 0; xsub = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_cout_ovf", {cout, ovf}, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_x_in_ready", x_ir, {NX{1'b1}});
        chk("reset_x_out_valid", x_ov, 0);

        // directed vectors, one at a time
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            in_valid = 1; a = vecs[t].a; b = vecs[t].b; cin = vecs[t].cin; sub = vecs[t].sub;
            #1 chk("vec_in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 0; a = MW'($urandom); b = MW'($urandom);
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", t), lat, MS);
            chk($sformatf("vec%0d_s", t), s, vecs[t].s);
            chk($sformatf("vec%0d_cout", t), cout, vecs[t].cout);
            chk($sformatf("vec%0d_ovf", t), ovf, vecs[t].ovf);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_single_beat", t), out_valid, 0);
        end

        // back-to-back stream with a three-cycle output stall
        sent = 0; got = 0; stall_prev = 0; held = '0; sub = 0; cin = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            a = MW'(sent); b = MW'(sent * 16);
            #1;
            if (stall_prev) chk("stream_stall_hold", s, held[MW-1:0]);
            if (out_valid && !out_ready) chk("stream_in_ready_full", in_ready, 0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream_s%0d", got), s, MW'(got * 17));
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held = 34'(s);
            if (in_valid && in_ready) sent++;
        end
        in_valid = 0; out_ready = 1;
        chk("stream_count", got, 8);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stream_no_extra", out_valid, 0);
        end

        // reset while two beats are in flight
        @(posedge clk); #1; in_valid = 1; a = 1; b = 1;
        @(posedge clk); #1; a = 2; b = 2;
        @(posedge clk); #1; in_valid = 0;
        chk("rst_pre_valid", out_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_out_valid_async", out_valid, 0);
        chk("rst_s_cleared", s, 0);
        @(posedge clk); #2 rst_n = 1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_no_stale", out_valid, 0);
        end
        in_valid = 1; a = 3; b = 4; cin = 0; sub = 0;
        @(posedge clk); #1; in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rst_new_latency", lat, MS);
        chk("rst_new_s", s, 7);

        // random traffic: main instance with backpressure, sweep instances free-running
        hold = 0; stall_prev = 0;
        for (int c = 0; c < NRAND + 20; c++) begin
            @(posedge clk); #1;
            if (!hold) begin
                in_valid = (c < NRAND) && ($urandom_range(0, 3) != 0);
                a = MW'($urandom); b = MW'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            out_ready = (c >= NRAND) || ($urandom_range(0, 3) != 0);
            xvalid = (c < NRAND) && ($urandom_range(0, 3) != 0);
            xa = $urandom; xb = $urandom;
            xcin = 1'($urandom_range(0, 1)); xsub = 1'($urandom_range(0, 1));
            #1;
            act = {ovf, cout, 32'(s)};
            if (stall_prev) chk("main_stall_hold", act, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("main_spurious_out", out_valid, 0);
                else chk("main_rand", act, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held = act;
            if (in_valid && in_ready) exp_q.push_back(ref_add(MW, 32'(a), 32'(b), cin, sub));
            hold = in_valid && !in_ready;
            for (int i = 0; i < NX; i++) begin
                if (x_ov[i]) begin
                    if (xq[i].size() == 0) chk($sformatf("x%0d_spurious_out", i), x_ov[i], 0);
                    else begin
                        chk($sformatf("x%0d_rand", i), {x_ovf[i], x_cout[i], x_s[i]}, xq[i].pop_front());
                        chk($sformatf("x%0d_latency", i), c - xt[i].pop_front(), CS[i]);
                    end
                end
                if (xvalid) begin
                    xq[i].push_back(ref_add(CW[i], xa, xb, xcin, xsub));
                    xt[i].push_back(c);
                end
            end
        end
        chk("main_drained", exp_q.size(), 0);
        for (int i = 0; i < NX; i++) chk($sformatf("x%0d_drained", i), xq[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
